riscv_ifu: RTL and testbench
============================

Name: riscv_ifu

Overview:
Instruction fetch unit directly upstream of the main control decoder. Holds the PC, issues one instruction-memory read at a time over a valid/ready request channel, and captures the returned word in an output register. Presents the word to decode with a valid/ready handshake; decode takes opcode = if_inst[6:0]. Accepts a redirect (branch/jump target) from execute at any time.

Parameters:
XLEN, 32, address/data width.
RESET_PC, 32'h8000_0000, PC value loaded by reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request.
imem_req_addr  output  XLEN  fetch address, word aligned.
imem_rsp_valid  input  1  read data valid; one-cycle pulse, one per accepted request, latency >= 1 cycle.
imem_rsp_data  input  32  instruction word.
redirect_valid  input  1  load new PC, squash in-flight/held instruction.
redirect_pc  input  XLEN  redirect target; bits [1:0] ignored, treated as 0.
if_valid  output  1  if_pc/if_inst valid for decode.
if_ready  input  1  decode consumes the instruction.
if_pc  output  XLEN  PC of presented instruction.
if_inst  output  32  presented instruction.

Behaviour:
- Reset (async assert): state=REQ, pc=RESET_PC, kill=0, if_valid=0, if_pc=0, if_inst=0. imem_req_valid=1 with addr RESET_PC in the first cycle after rst deasserts (it is also driven combinationally from state REQ during reset).
- Single outstanding request maximum. imem_req_addr = pc whenever imem_req_valid=1.
- States:
  REQ: imem_req_valid=1. On imem_req_ready -> WAIT.
  WAIT: imem_req_valid=0. On imem_rsp_valid: if kill=1, drop the word, clear kill, -> REQ; otherwise if_inst<=rsp_data, if_pc<=pc, if_valid<=1, pc<=pc+4, -> HOLD.
  HOLD: if_valid=1, outputs stable. On if_valid&&if_ready: if_valid<=0, -> REQ.
- Throughput: with a 1-cycle memory and if_ready tied to 1, one instruction every 3 cycles (REQ, WAIT, HOLD).
- PC arithmetic: pc+4 modulo 2^XLEN; 0xFFFF_FFFC wraps to 0 with no error.
- Redirect (highest priority, any state, single cycle): pc<=redirect_pc with [1:0]=0; if_valid<=0 next cycle. Next state:
  REQ without handshake this cycle -> REQ. imem_req_addr changes to the new pc next cycle. The memory side tolerates a retracted or changed request before acceptance.
  REQ with handshake this cycle -> WAIT, kill<=1. The old-address response is dropped.
  WAIT, no response this cycle -> WAIT, kill<=1.
  WAIT, response this cycle -> REQ. The response is dropped and not captured.
  HOLD, whether or not if_ready is high -> REQ. Held instruction squashed; if consumed in the same cycle, decode is responsible for squashing it.
- Redirect with kill already 1: kill stays 1, pc updated.
- imem_rsp_valid outside WAIT: ignored. This is a protocol error and an assertion in the bench.
- if_ready while if_valid=0: no effect.
- Reset mid-operation clears kill. Any response that arrives after reset for a pre-reset request is a protocol violation; the memory is reset from the same rst.
- No combinational path from if_ready or imem_rsp_* to any output. Only imem_req_valid/addr depend on state and pc registers.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning 0x0000_0013, if_ready=1: if_valid pulses every 3 cycles with if_pc = 0x8000_0000, 0x8000_0004, 0x8000_0008, and if_inst = 0x0000_0013.
- if_ready=0 for 5 cycles with an instruction held: if_valid stays 1 and if_pc/if_inst are stable. imem_req_valid=0 throughout. The next request goes out the cycle after if_ready rises.
- imem_req_ready low for 4 cycles: imem_req_valid stays 1 with a stable address. Then redirect_valid with redirect_pc=0x8000_0102: the next address is 0x8000_0100.
- Redirect to 0x8000_0200 in WAIT, response arriving 3 cycles later: if_valid never asserts for the old PC. The next request address is 0x8000_0200.
- Redirect in the same cycle as a REQ handshake: the response is dropped. The next request is to the redirect target; the first if_pc equals the target.
- PC at 0xFFFF_FFFC after fetch: the next request address is 0x0000_0000. Asserting rst during WAIT: if_valid=0 immediately and the next request is to RESET_PC.

Source files
------------

// File: rtl/riscv_ifu.sv
// Instruction fetch unit: owns the PC, keeps one instruction-memory read in
// flight at most, and hands each returned word to decode over valid/ready.
module riscv_ifu #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst
);

  localparam int unsigned     INST_W  = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [XLEN-1:0]     pc, pc_nxt;
  logic                kill, kill_nxt;
  logic                if_valid_nxt;
  logic [XLEN-1:0]     if_pc_nxt;
  logic [INST_W-1:0]   if_inst_nxt;
  logic [XLEN-1:0]     redirect_target;

  // Targets are always word aligned; the two low bits carry no information.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      kill     <= kill_nxt;
      if_valid <= if_valid_nxt;
      if_pc    <= if_pc_nxt;
      if_inst  <= if_inst_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    kill_nxt       = kill;
    if_valid_nxt   = if_valid;
    if_pc_nxt      = if_pc;
    if_inst_nxt    = if_inst;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc;

    case (state)
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill) begin
            // Response belongs to a squashed fetch.
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            if_inst_nxt  = imem_rsp_data;
            if_pc_nxt    = pc;
            if_valid_nxt = 1'b1;
            pc_nxt       = pc + PC_STEP;
            state_nxt    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (if_ready) begin
          if_valid_nxt = 1'b0;
          state_nxt    = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase

    // Redirect overrides everything decided above.
    if (redirect_valid) begin
      pc_nxt       = redirect_target;
      if_valid_nxt = 1'b0;
      if_pc_nxt    = if_pc;
      if_inst_nxt  = if_inst;
      case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            state_nxt = S_WAIT;
            kill_nxt  = 1'b1;
          end else begin
            state_nxt = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_nxt = S_REQ;
            kill_nxt  = 1'b0;
          end else begin
            state_nxt = S_WAIT;
            kill_nxt  = 1'b1;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_ifu.sv
// Bench for riscv_ifu: behavioural memory, directed scenarios, then random
// traffic checked against the expected sequential instruction stream.
module tb_riscv_ifu;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  riscv_ifu #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst)
  );

  int n_vec = 0;
  int n_mis = 0;
  int hs_count = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_exp_pc;
  bit          const_mode = 1'b1;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (const_mode) return 32'h0000_0013;
    return (a * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view: decode sees consecutive words starting at the
  // most recent reset/redirect target.
  task automatic top_up();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc   = next_exp_pc;
      e.inst = mem_word(next_exp_pc);
      exp_q.push_back(e);
      next_exp_pc = next_exp_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    next_exp_pc = pc;
    top_up();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: one response per accepted request after a random latency.
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pdata;
  initial begin
    bit          acc;
    logic [31:0] acc_addr;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      acc      = !rst && imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      @(posedge clk);
      #2;
      imem_rsp_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (acc) begin
          check("single_outstanding", 32'(pend), 32'd0);
          pend  = 1'b1;
          cnt   = $urandom_range(lat_max, lat_min) - 1;
          pdata = mem_word(acc_addr);
        end else if (pend && cnt > 0) begin
          cnt--;
        end
        if (pend && cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = pdata;
          pend           = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pop on each decode handshake plus protocol checks.
  bit          prev_req_stall = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr, prev_ipc, prev_iinst;
  int          idle = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_req_stall = 1'b0;
      prev_hold      = 1'b0;
      idle           = 0;
    end else begin
      if (prev_req_stall) begin
        check("req_stall_valid", 32'(imem_req_valid), 32'd1);
        check("req_stall_addr", imem_req_addr, prev_addr);
      end
      if (prev_hold) begin
        check("hold_valid", 32'(if_valid), 32'd1);
        check("hold_pc", if_pc, prev_ipc);
        check("hold_inst", if_inst, prev_iinst);
      end
      if (imem_req_valid) check("req_align", 32'(imem_req_addr[1:0]), 32'd0);
      if (imem_rsp_valid) check("rsp_outside_wait", 32'(imem_req_valid), 32'd0);
      if (if_valid && if_ready && !redirect_valid) begin
        idle = 0;
        hs_count++;
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("if_pc", if_pc, e.pc);
          check("if_inst", if_inst, e.inst);
          top_up();
        end
      end else begin
        idle++;
        if (idle > 300) begin
          check("watchdog_no_progress", 32'd1, 32'd0);
          idle = 0;
        end
      end
      prev_req_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_addr      = imem_req_addr;
      prev_hold      = if_valid && !if_ready && !redirect_valid;
      prev_ipc       = if_pc;
      prev_iinst     = if_inst;
    end
  end

  initial begin
    logic [31:0] rt;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    restart(RESET_PC);
    #3;
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    repeat (2) tick();
    rst = 1'b0;

    // Steady stream: one instruction every third cycle.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("tput_if_valid", 32'(if_valid), 32'((k % 3) == 2));
      if (k == 0) check("first_req_addr", imem_req_addr, RESET_PC);
    end

    // Decode back-pressure.
    tick();
    if_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20 && !if_valid; i++) @(negedge clk);
    check("hold_reached", 32'(if_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_no_req", 32'(imem_req_valid), 32'd0);
    end
    tick();
    if_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("req_after_release", 32'(imem_req_valid), 32'd1);

    // Memory back-pressure, then redirect while stalled.
    tick();
    imem_req_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20 && !imem_req_valid; i++) @(negedge clk);
    check("stall_reached", 32'(imem_req_valid), 32'd1);
    repeat (4) @(negedge clk);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    restart(32'h8000_0100);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h8000_0100);
    tick();
    imem_req_ready = 1'b1;

    // Redirect while waiting on a slow response.
    lat_min = 3;
    lat_max = 3;
    @(negedge clk);
    for (int i = 0; i < 20 && !(imem_req_valid && imem_req_ready); i++) @(negedge clk);
    check("wait_hs_a", 32'(imem_req_valid && imem_req_ready), 32'd1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    restart(32'h8000_0200);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20 && !imem_req_valid; i++) @(negedge clk);
    check("wait_redir_addr", imem_req_addr, 32'h8000_0200);

    // Redirect coinciding with the request handshake.
    lat_min = 1;
    lat_max = 3;
    @(negedge clk);
    for (int i = 0; i < 20 && !(imem_req_valid && imem_req_ready); i++) @(negedge clk);
    check("wait_hs_b", 32'(imem_req_valid && imem_req_ready), 32'd1);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    restart(32'h8000_0300);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20 && !imem_req_valid; i++) @(negedge clk);
    check("hs_redir_addr", imem_req_addr, 32'h8000_0300);

    // PC wrap at the top of the address space.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    restart(32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 30 && !(imem_req_valid && imem_req_addr != 32'hFFFF_FFFC); i++)
      @(negedge clk);
    check("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Reset while a fetch is outstanding.
    for (int i = 0; i < 20 && !(imem_req_valid && imem_req_ready); i++) @(negedge clk);
    check("wait_hs_c", 32'(imem_req_valid && imem_req_ready), 32'd1);
    tick();
    rst        = 1'b1;
    const_mode = 1'b0;
    restart(RESET_PC);
    #1;
    check("mid_rst_if_valid", 32'(if_valid), 32'd0);
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("mid_rst_req_addr", imem_req_addr, RESET_PC);
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_addr", imem_req_addr, RESET_PC);

    // Random traffic.
    lat_min = 1;
    lat_max = 4;
    for (int c = 0; c < 3000; c++) begin
      tick();
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = 1'b0;
      if ($urandom_range(0, 23) == 0) begin
        rt = $urandom;
        if ($urandom_range(0, 3) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'h0000_000F);
        redirect_valid = 1'b1;
        redirect_pc    = rt;
        restart(rt & 32'hFFFF_FFFC);
      end
    end
    tick();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("progress", 32'(hs_count > 150), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
